// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU function codes, multiply/divide op codes and the
//               multiply/divide engine state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [1:0] GRP_ARITH = 2'b00;
    localparam logic [1:0] GRP_LOGIC = 2'b01;
    localparam logic [1:0] GRP_SHIFT = 2'b10;
    localparam logic [1:0] GRP_CMP   = 2'b11;

    localparam logic [5:0] ADD = 6'b000000;
    localparam logic [5:0] SUB = 6'b000001;
    localparam logic [5:0] AND = 6'b011000;
    localparam logic [5:0] OR  = 6'b011110;
    localparam logic [5:0] XOR = 6'b010110;
    localparam logic [5:0] NOR = 6'b010001;
    localparam logic [5:0] SLL = 6'b100000;
    localparam logic [5:0] SRL = 6'b100001;
    localparam logic [5:0] SRA = 6'b100011;
    // Compare conditions live in bits [3:1]; bit 0 is ignored by the decoder.
    localparam logic [5:0] NEQ = 6'b110001;
    localparam logic [5:0] EQ  = 6'b110011;
    localparam logic [5:0] LT  = 6'b110101;
    localparam logic [5:0] LTZ = 6'b111011;
    localparam logic [5:0] LEZ = 6'b111101;
    localparam logic [5:0] GTZ = 6'b111111;

    localparam logic MD_MUL = 1'b0;
    localparam logic MD_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_md_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_md_if
// Description : Operand, function-code, multiply/divide handshake and result
//               bundle between the datapath and the execute unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_md_if #(
    parameter int W = 32
);
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [5:0]   ALUFun;
    logic         Sign;
    logic         md_start;
    logic         md_op;
    logic         md_flush;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] S;
    logic         md_busy;
    logic         md_done;
    logic         md_dz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    modport master (
        output A, B, ALUFun, Sign, md_start, md_op, md_flush, hi_we, lo_we,
        input  S, md_busy, md_done, md_dz, hi, lo
    );

    modport slave (
        input  A, B, ALUFun, Sign, md_start, md_op, md_flush, hi_we, lo_we,
        output S, md_busy, md_done, md_dz, hi, lo
    );
endinterface : alu_md_if
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : Iterative shift-add multiplier / restoring divider with HI/LO
//               registers, flush and divide-by-zero handling.
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic [W-1:0] i_a,
    input  wire logic [W-1:0] i_b,
    input  wire logic         i_sign,
    input  wire logic         i_start,
    input  wire logic         i_op,
    input  wire logic         i_flush,
    input  wire logic         i_hi_we,
    input  wire logic         i_lo_we,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_dz,
    output logic [W-1:0]      o_hi,
    output logic [W-1:0]      o_lo
);
    localparam int              c_cnt_w = $clog2(W);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(W - 1);

    md_state_t        r_state;
    md_state_t        w_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [W-1:0]     r_ma, r_mb, r_ph, r_pl, r_hi, r_lo;
    logic             r_op, r_neg_a, r_neg_b, r_zero, r_done, r_dz;
    logic             w_accept, w_fix_we;
    logic [W-1:0]     w_ma, w_mb, w_fix_hi, w_fix_lo;
    logic [W:0]       w_sum, w_shift, w_diff;
    logic [2*W-1:0]   w_nprod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Flush wins over everything, including the result write in FIX.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_fix_we = 1'b0;
        o_busy   = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (i_start && !i_flush) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end
            end
            RUN: begin
                if (i_flush)             w_next = IDLE;
                else if (r_cnt == c_last) w_next = FIX;
            end
            FIX: begin
                w_next   = IDLE;
                w_fix_we = !i_flush;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_ma    = (i_sign && i_a[W-1]) ? -i_a : i_a;
    assign w_mb    = (i_sign && i_b[W-1]) ? -i_b : i_b;
    assign w_sum   = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_ma} : '0);
    assign w_shift = {r_ph, r_pl[W-1]};
    assign w_diff  = w_shift - {1'b0, r_mb};

    always_comb begin
        w_fix_hi = r_ph;
        w_fix_lo = r_pl;
        w_nprod  = -{r_ph, r_pl};
        if (r_zero) begin
            w_fix_hi = r_neg_a ? -r_ma : r_ma;
            w_fix_lo = '1;
        end else if (r_op == MD_MUL) begin
            if (r_neg_a ^ r_neg_b) {w_fix_hi, w_fix_lo} = w_nprod;
        end else begin
            if (r_neg_a ^ r_neg_b) w_fix_lo = -r_pl;
            if (r_neg_a)           w_fix_hi = -r_ph;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_ma    <= '0;
            r_mb    <= '0;
            r_ph    <= '0;
            r_pl    <= '0;
            r_op    <= MD_MUL;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
            r_zero  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= w_fix_we;
            if (w_accept) begin
                r_ma    <= w_ma;
                r_mb    <= w_mb;
                r_op    <= i_op;
                r_neg_a <= i_sign & i_a[W-1];
                r_neg_b <= i_sign & i_b[W-1];
                r_zero  <= (i_op == MD_DIV) && (i_b == '0);
                r_cnt   <= '0;
                r_dz    <= 1'b0;
                r_ph    <= '0;
                r_pl    <= (i_op == MD_DIV) ? w_ma : w_mb;
            end else if (r_state == RUN && !i_flush) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
                if (!r_zero) begin
                    if (r_op == MD_MUL) begin
                        r_ph <= w_sum[W:1];
                        r_pl <= {w_sum[0], r_pl[W-1:1]};
                    end else if (!w_diff[W]) begin
                        r_ph <= w_diff[W-1:0];
                        r_pl <= {r_pl[W-2:0], 1'b1};
                    end else begin
                        r_ph <= w_shift[W-1:0];
                        r_pl <= {r_pl[W-2:0], 1'b0};
                    end
                end
            end
            // A same-cycle accepted start drops MTHI/MTLO.
            if (w_fix_we) begin
                r_hi <= w_fix_hi;
                r_lo <= w_fix_lo;
                if (r_zero) r_dz <= 1'b1;
            end else if (!o_busy && !w_accept) begin
                if (i_hi_we) r_hi <= i_a;
                if (i_lo_we) r_lo <= i_a;
            end
        end
    end

    assign o_done = r_done;
    assign o_dz   = r_dz;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule : md_unit
`default_nettype wire

// File: rtl/alu_md.sv
`default_nettype none
// ============================================================================
// Module      : alu_md
// Description : MIPS32 execute unit: combinational ALU (arith/logic/shift/
//               compare) plus iterative multiply/divide engine with HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_md
    import alu_pkg::*;
#(
    parameter int W   = 32,
    parameter int SHW = $clog2(W)
) (
    input  wire logic clk,
    input  wire logic rst_n,
    alu_md_if.slave   bus
);
    logic         w_cmp, w_left, w_fill;
    logic [W-1:0] w_logic, w_sh_in, w_sh_rev, w_sh_last, w_sh_out;

    always_comb begin
        w_cmp = 1'b0;
        case (bus.ALUFun[3:1])
            NEQ[3:1]: w_cmp = (bus.A != bus.B);
            EQ[3:1]:  w_cmp = (bus.A == bus.B);
            LT[3:1]:  w_cmp = bus.Sign ? ($signed(bus.A) < $signed(bus.B)) : (bus.A < bus.B);
            LTZ[3:1]: w_cmp = bus.A[W-1];
            LEZ[3:1]: w_cmp = bus.A[W-1] || (bus.A == '0);
            GTZ[3:1]: w_cmp = !bus.A[W-1] && (bus.A != '0);
            default:  w_cmp = 1'b0;
        endcase
    end

    always_comb begin
        w_logic = bus.A;
        case (bus.ALUFun[3:0])
            AND[3:0]: w_logic = bus.A & bus.B;
            OR[3:0]:  w_logic = bus.A | bus.B;
            XOR[3:0]: w_logic = bus.A ^ bus.B;
            NOR[3:0]: w_logic = ~(bus.A | bus.B);
            default:  w_logic = bus.A;
        endcase
    end

    // Left shifts reuse the right-shift barrel by bit-reversing in and out.
    assign w_left = (bus.ALUFun[0] == SLL[0]);
    assign w_fill = (bus.ALUFun[1:0] == SRA[1:0]) & bus.B[W-1];

    for (genvar gi = 0; gi < W; gi++) begin : g_rev
        assign w_sh_in[gi]  = w_left ? bus.B[W-1-gi] : bus.B[gi];
        assign w_sh_rev[gi] = w_sh_last[W-1-gi];
    end

    for (genvar gs = 0; gs < SHW; gs++) begin : g_stage
        localparam int c_step = 1 << gs;
        logic [W-1:0] w_in;
        logic [W-1:0] w_out;
        if (gs == 0) begin : g_first
            assign w_in = w_sh_in;
        end else begin : g_next
            assign w_in = g_stage[gs-1].w_out;
        end
        assign w_out = bus.A[gs] ? {{c_step{w_fill}}, w_in[W-1:c_step]} : w_in;
    end

    assign w_sh_last = g_stage[SHW-1].w_out;
    assign w_sh_out  = w_left ? w_sh_rev : w_sh_last;

    always_comb begin
        bus.S = '0;
        case (bus.ALUFun[5:4])
            GRP_ARITH: bus.S = (bus.ALUFun[0] == SUB[0]) ? bus.A - bus.B : bus.A + bus.B;
            GRP_LOGIC: bus.S = w_logic;
            GRP_SHIFT: bus.S = w_sh_out;
            GRP_CMP:   bus.S = {{(W-1){1'b0}}, w_cmp};
            default:   bus.S = '0;
        endcase
    end

    md_unit #(.W(W)) u_md (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_a     (bus.A),
        .i_b     (bus.B),
        .i_sign  (bus.Sign),
        .i_start (bus.md_start),
        .i_op    (bus.md_op),
        .i_flush (bus.md_flush),
        .i_hi_we (bus.hi_we),
        .i_lo_we (bus.lo_we),
        .o_busy  (bus.md_busy),
        .o_done  (bus.md_done),
        .o_dz    (bus.md_dz),
        .o_hi    (bus.hi),
        .o_lo    (bus.lo)
    );

endmodule : alu_md
`default_nettype wire
